// File: rtl/map_rom_arbiter_if.sv
// Lookup port between the game-logic FSM and map_rom_arbiter.
//   master : game logic -- drives lk_req/lk_x/lk_y, receives the result
//   slave  : arbiter    -- returns lk_ack/lk_data/lk_err/lk_waits
// lk_req is held high until lk_ack. lk_data is valid while lk_ack=1 and is
// held afterwards. lk_err is raised with lk_ack for an out-of-range
// coordinate. lk_waits is a saturating count of the cycles a request waited
// for the ROM.
interface map_rom_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);
  logic              lk_req;
  logic [8:0]        lk_x;
  logic [8:0]        lk_y;
  logic              lk_ack;
  logic [DATA_W-1:0] lk_data;
  logic              lk_err;
  logic [CNT_W-1:0]  lk_waits;

  modport master (
    output lk_req, lk_x, lk_y,
    input  lk_ack, lk_data, lk_err, lk_waits
  );

  modport slave (
    input  lk_req, lk_x, lk_y,
    output lk_ack, lk_data, lk_err, lk_waits
  );
endinterface

// File: rtl/map_rom_arbiter.sv
// Shares the single-port map background ROM between two users. The ROM
// registers its address, so its data appears one cycle after the address.
//   - Video pixel fetch. It owns the ROM whenever blank=1 (active display).
//   - Game-logic lookups (tile/collision queries). These are served only
//     while blank=0.
// Ports:
//   vga_clk     pixel clock; all state changes on the rising edge
//   Reset       synchronous, active-high
//   DrawX/DrawY current pixel column/row (0..639 / 0..479)
//   blank       1 = active video, 0 = blanking
//   rom_address ROM address (combinational mux)
//   rom_q       ROM data, one cycle after rom_address
//   pix_index   palette index for video, 2 cycles after DrawX/DrawY
//   pix_valid   pix_index belongs to an active pixel
//   lk          lookup port (slave side of map_rom_arbiter_if)
module map_rom_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 4,
  parameter int MAP_W  = 256,
  parameter int MAP_H  = 256,
  parameter int CNT_W  = 16
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] pix_index,
  output logic              pix_valid,
  map_rom_arbiter_if.slave  lk
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  localparam logic [19:0] MAP_W_20 = 20'(MAP_W);
  localparam logic [19:0] MAP_H_20 = 20'(MAP_H);

  logic [1:0]        state;
  logic              blank_d1;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic [CNT_W-1:0]  waits_q;

  logic [19:0]       vx;
  logic [19:0]       vy;
  logic [ADDR_W-1:0] vaddr;
  logic [ADDR_W-1:0] laddr;
  logic              out_of_range;

  // Scale the 640x480 screen onto the map, truncating. With 20-bit
  // intermediates the products (at most 639*256) cannot overflow.
  always_comb begin
    vx           = ({10'd0, DrawX} * MAP_W_20) / 20'd640;
    vy           = ({10'd0, DrawY} * MAP_H_20) / 20'd480;
    vaddr        = ADDR_W'(vx + vy * MAP_W_20);
    laddr        = ADDR_W'({11'd0, lk.lk_y} * MAP_W_20 + {11'd0, lk.lk_x});
    out_of_range = ({11'd0, lk.lk_x} >= MAP_W_20) || ({11'd0, lk.lk_y} >= MAP_H_20);
  end

  // Video wins whenever blank=1. That includes a blank that rises during
  // ISSUE, so the display never fetches from a lookup address.
  assign rom_address = (state == ISSUE && !blank) ? laddr : vaddr;

  assign lk.lk_ack   = (state == ACK);
  assign lk.lk_data  = data_q;
  assign lk.lk_err   = err_q;
  assign lk.lk_waits = waits_q;

  // NOTE: all state below uses non-blocking assignments. Every register then
  // samples pre-edge values, and the result does not depend on the order of
  // the statements.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state     <= IDLE;
      blank_d1  <= 1'b0;
      pix_index <= '0;
      pix_valid <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      waits_q   <= '0;
    end else begin
      // The address goes out in cycle 0 and rom_q is valid in cycle 1. It is
      // registered here, so pix_index/pix_valid line up with the blank that
      // came with the address two cycles earlier.
      blank_d1  <= blank;
      pix_valid <= blank_d1;
      pix_index <= blank_d1 ? rom_q : '0;

      case (state)
        IDLE: begin
          if (lk.lk_req) begin
            if (out_of_range) begin
              // Answer at once and never touch the ROM.
              data_q <= '0;
              err_q  <= 1'b1;
              state  <= ACK;
            end else if (!blank) begin
              state <= ISSUE;
            end else if (waits_q != '1) begin
              waits_q <= waits_q + 1'b1;
            end
          end
        end
        // Once issued, the lookup completes even if lk_req drops. A blank that
        // rises in this cycle takes the ROM back, and the request is retried
        // from IDLE.
        ISSUE:   state <= blank ? IDLE : CAPTURE;
        CAPTURE: begin
          data_q <= rom_q;
          err_q  <= 1'b0;
          state  <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
